// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1RW+1R byte-masked SRAM.
// Holds the init FSM state type and the byte merge used by write paths.
package sram_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Widest word the merge helper handles; callers zero-extend.
    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_WMASKS     = MAX_DATA_WIDTH / 8;

    // Replace each byte of old_word whose mask bit is set.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_WMASKS-1:0]     mask
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_WMASKS; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset init sequencer: sweeps every address once, then
// raises ready and stays in RUN until the next reset.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int INIT_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic                  ready
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t state;

    // No sweep write while reset is held, so address 0 is not touched early.
    assign init_we = (state == S_INIT) && !rst;

    // Sweep counter and INIT -> RUN transition; ready rises with the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (INIT_EN != 0) ? S_INIT : S_RUN;
            init_addr <= '0;
            ready     <= (INIT_EN == 0);
        end else begin
            if (state == S_INIT) begin
                if (init_addr == LAST_ADDR) begin
                    state <= S_RUN;
                    ready <= 1'b1;
                end else begin
                    init_addr <= init_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural SRAM: port 0 read/write with byte mask, port 1 read only,
// 1-cycle read latency, write-through on a same-address collision.
module sram_1rw1r_wmask
    import sram_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 10,
    parameter int                  INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk0,
    input  logic                    rst0,
    input  logic                    csb0,
    input  logic                    web0,
    input  logic [DATA_WIDTH/8-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]   din0,
    output logic [DATA_WIDTH-1:0]   dout0,
    output logic                    dout0_valid,
    input  logic                    csb1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    output logic [DATA_WIDTH-1:0]   dout1,
    output logic                    dout1_valid,
    output logic                    ready
);

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  wr0;
    logic                  rd0;
    logic                  rd1;
    logic                  collide;
    logic [DATA_WIDTH-1:0] wr_word;

    sram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_EN    (INIT_EN)
    ) u_init_seq (
        .clk       (clk0),
        .rst       (rst0),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    // Requests are only honoured once the sweep has finished.
    assign wr0     = ready && !csb0 && !web0;
    assign rd0     = ready && !csb0 &&  web0;
    assign rd1     = ready && !csb1;
    assign collide = wr0 && (addr0 == addr1);

    // Merged word for port 0; also the write-through value for port 1.
    assign wr_word = DATA_WIDTH'(byte_merge(
        MAX_DATA_WIDTH'(mem[addr0]),
        MAX_DATA_WIDTH'(din0),
        MAX_WMASKS'(wmask0)
    ));

    // Array update: sweep fill during INIT, masked writes in RUN.
    always_ff @(posedge clk0) begin
        if (init_we) begin
            mem[init_addr] <= INIT_VALUE;
        end else if (wr0 && (wmask0 != '0)) begin
            mem[addr0] <= wr_word;
        end
    end

    // Port 0 read register; holds data when idle or writing.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            dout0       <= '0;
            dout0_valid <= 1'b0;
        end else begin
            dout0_valid <= rd0;
            if (rd0) begin
                dout0 <= mem[addr0];
            end
        end
    end

    // Port 1 read register with write-through from port 0.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            dout1       <= '0;
            dout1_valid <= 1'b0;
        end else begin
            dout1_valid <= rd1;
            if (rd1) begin
                dout1 <= collide ? wr_word : mem[addr1];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{NUM_WMASKS[0]};

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Self-checking bench for sram_1rw1r_wmask with a word-array model.
module tb_sram_1rw1r_wmask;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] IV    = 32'hDEADBEEF;

    logic        clk0   = 1'b0;
    logic        rst0   = 1'b1;
    logic        csb0   = 1'b1;
    logic        web0   = 1'b1;
    logic [3:0]  wmask0 = '0;
    logic [3:0]  addr0  = '0;
    logic [31:0] din0   = '0;
    logic        csb1   = 1'b1;
    logic [3:0]  addr1  = '0;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic        dout0_valid;
    logic        dout1_valid;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_d0 = '0;
    logic [31:0] exp_d1 = '0;

    sram_1rw1r_wmask #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .INIT_EN    (1),
        .INIT_VALUE (IV)
    ) dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .dout0       (dout0),
        .dout0_valid (dout0_valid),
        .csb1        (csb1),
        .addr1       (addr1),
        .dout1       (dout1),
        .dout1_valid (dout1_valid),
        .ready       (ready)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of traffic; the model applies the spec rules:
    // masked bytes replace old ones, port 1 sees the post-write word.
    task automatic step(input logic c0, input logic w0,
                        input logic [3:0] m, input logic [3:0] a0,
                        input logic [31:0] d, input logic c1,
                        input logic [3:0] a1);
        logic [31:0] nw;
        logic        r0;
        logic        r1;
        csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d;
        csb1 = c1; addr1 = a1;
        r0 = !c0 && w0;
        r1 = !c1;
        if (r0) exp_d0 = ref_mem[a0];
        if (!c0 && !w0) begin
            nw = ref_mem[a0];
            for (int b = 0; b < 4; b++)
                if (m[b]) nw[8*b +: 8] = d[8*b +: 8];
            ref_mem[a0] = nw;
        end
        if (r1) exp_d1 = ref_mem[a1];
        @(posedge clk0); #1;
        chk("dout0", dout0, exp_d0);
        chk("dout0_valid", 32'(dout0_valid), 32'(r0));
        chk("dout1", dout1, exp_d1);
        chk("dout1_valid", 32'(dout1_valid), 32'(r1));
        chk("ready_run", 32'(ready), 32'd1);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] ra;
        repeat (3) @(posedge clk0);
        #1;
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_v0", 32'(dout0_valid), 32'h0);
        chk("rst_v1", 32'(dout1_valid), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);

        rst0 = 1'b0;
        repeat (7) @(posedge clk0);
        #2;
        chk("sweep_ready_low", 32'(ready), 32'h0);
        rst0 = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'h0);
        chk("midrst_dout0", dout0, 32'h0);
        chk("midrst_dout1", dout1, 32'h0);
        @(posedge clk0); #1;

        // Dropped requests presented during the whole sweep.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'd2;
        din0 = 32'h0; csb1 = 1'b0; addr1 = 4'd2;
        rst0 = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk0); #1;
            n++;
            chk("sweep_v0", 32'(dout0_valid), 32'h0);
            chk("sweep_v1", 32'(dout1_valid), 32'h0);
        end
        chk("sweep_cycles", 32'(n), 32'd16);
        chk("drop_dout0", dout0, 32'h0);
        chk("drop_dout1", dout1, 32'h0);
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;

        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 4'(i));

        step(1'b0, 1'b0, 4'hF, 4'd3, 32'h11223344, 1'b1, 4'd0);
        step(1'b0, 1'b0, 4'b0101, 4'd3, 32'hAABBCCDD, 1'b1, 4'd0);
        step(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'd0);
        chk("rd_addr3", dout0, 32'h11BB33DD);
        chk("rd_addr3_v", 32'(dout0_valid), 32'd1);
        idle();
        chk("hold_addr3", dout0, 32'h11BB33DD);
        chk("hold_addr3_v", 32'(dout0_valid), 32'd0);

        step(1'b0, 1'b0, 4'b1100, 4'd5, 32'hCAFEF00D, 1'b0, 4'd5);
        chk("collision", dout1, 32'hCAFEBEEF);

        step(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd2);
        chk("dropped_addr2", dout1, IV);

        step(1'b0, 1'b0, 4'h0, 4'd7, 32'h12345678, 1'b0, 4'd7);
        chk("zero_mask", dout1, IV);

        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 3) == 0), 1'($urandom),
                 4'($urandom), ra, $urandom,
                 1'($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0) ? ra
                                             : 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_wmask.md
Name: sram_1rw1r_wmask

Overview:
- Parametrised successor of the fixed 32x1024 single-port SRAM model: one read/write port with byte write mask, plus one independent read-only port.
- Fully synchronous, posedge only, no delays; synthesisable behavioural model.
- Includes a post-reset init sweep that fills memory with a known value, and a ready/valid status interface.
- Used as instruction/data memory behind the core's fetch (port 1) and load/store (port 0) units.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words (derived).
- NUM_WMASKS, DATA_WIDTH/8, number of byte-enable bits (derived).
- INIT_EN, 1, 1 = sweep-fill memory after reset; 0 = no sweep.
- INIT_VALUE, 0, DATA_WIDTH-bit fill word written during the sweep.

Ports:
- clk0  in  1  clock; all logic on posedge.
- rst0  in  1  reset, asynchronous, active-high.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  NUM_WMASKS  port 0 byte enables, bit i covers din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dout0_valid  out  1  dout0 holds data for the previous cycle's accepted read.
- csb1  in  1  port 1 chip select, active low (read only).
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- dout1_valid  out  1  dout1 valid, same timing as dout0_valid.
- ready  out  1  high when requests are accepted.

Behaviour:
- Reset (async, on assertion of rst0):
  - dout0 and dout1 = 0; both valid flags = 0.
  - ready = 0 if INIT_EN = 1, else 1.
  - FSM = INIT if INIT_EN = 1, else RUN; init_addr = 0.
  - Memory array is not reset.
- FSM states: INIT and RUN.
  - INIT: each cycle writes INIT_VALUE to mem[init_addr] and increments init_addr.
  - When init_addr == RAM_DEPTH-1, the write completes and the FSM moves to RUN; ready rises that edge.
  - The sweep takes exactly RAM_DEPTH cycles after the first clock edge following reset release.
  - Reset asserted mid-sweep restarts the sweep at address 0.
  - RUN is terminal until the next reset.
- Requests sampled while ready = 0 are dropped: no memory write, valid flags stay 0, dout values are held.
- Port 0 write (ready, csb0 = 0, web0 = 0) at posedge N:
  - For each i with wmask0[i] = 1, mem[addr0] byte i <= din0 byte i; other bytes are unchanged.
  - wmask0 = 0 is a legal no-op write.
  - dout0_valid = 0 after edge N; dout0 is held.
- Port 0 read (ready, csb0 = 0, web0 = 1) at posedge N:
  - dout0 <= mem[addr0] and dout0_valid <= 1 after edge N (1-cycle latency).
- Port 1 read (ready, csb1 = 0) at posedge N: dout1 <= mem[addr1] and dout1_valid <= 1, same latency.
- No request on a port (csb high): that port's valid <= 0 and its dout holds its last value (never X).
- Collision: port 0 write and port 1 read to the same address in the same cycle → write-through.
  - dout1 = old word with the masked bytes replaced by din0 bytes.
- Back-to-back accesses every cycle are supported on both ports; there are no stall cycles in RUN.
- Address width equals log2(RAM_DEPTH), so there is no out-of-range address; init_addr wraps are never reached because the FSM exits INIT first.

Decomposition:
- Shared package sram_pkg: state enum {S_INIT, S_RUN}; function byte_merge(old, new, mask) used by both the write path and the write-through path.
- One sub-module, sram_init_seq: FSM, init_addr counter and ready output.
- The array and the port logic stay in the top module.

Test Plan (DATA_WIDTH = 32, ADDR_WIDTH = 4 for bench speed):
- Release reset, INIT_VALUE = 32'hDEADBEEF → ready rises exactly 16 cycles later; port 1 reads of addr 0..15 all return 32'hDEADBEEF with dout1_valid = 1 one cycle after each request.
- After init: write addr 3, din0 = 32'h11223344, wmask0 = 4'b1111, then write 32'hAABBCCDD with wmask0 = 4'b0101 → port 0 read of addr 3 returns 32'h11BB33DD.
- Same cycle: port 0 writes addr 5 = 32'hCAFEF00D with mask 4'b1100 (old value 32'hDEADBEEF); port 1 reads addr 5 → dout1 = 32'hCAFEBEEF.
- Requests issued while ready = 0 (write addr 2 = 32'h0) → dropped; valid flags stay 0; a later read of addr 2 returns INIT_VALUE.
- Reset pulsed at sweep cycle 7 → dout0/dout1 = 0 and ready = 0 immediately; after release the sweep restarts and ready rises 16 cycles later.
- Port 0 read addr 3 followed by an idle cycle → dout0 = 32'h11BB33DD held; dout0_valid goes 1 then 0.
